// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-port, byte-enabled data BRAM between the
//             instruction-fetch path and the load/store path. Every access
//             takes three cycles: IDLE (arbitrate and latch), ISSUE (BRAM
//             strobe), DONE (ack and return extended read data).
//  Options  : define MISALIGN_TRAP_EN to trap misaligned half/word data
//             accesses (no BRAM strobe, d_err=1 with d_ack).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_ack,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic          d_sign,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_ack,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_grant;
  logic          w_gnt_d;
  logic          w_mis;
  logic          w_en;
  logic          w_store;
  logic [3:0]    w_mask;
  logic [31:0]   w_wdata;
  logic          w_trap;

  // Latched attributes of the access in flight (needed in DONE)
  logic          r_last_d;   // 1 = data port won the last grant
  logic          r_gnt_d;
  logic          r_we;
  logic          r_sign;
  logic [1:0]    r_size;
  logic [1:0]    r_off;

  logic [7:0]    w_lane8;
  logic [15:0]   w_lane16;
  logic [31:0]   w_ext;
  logic          w_done;

  // Upper address bits and fetch offset are intentionally ignored
  logic          w_unused;
  assign w_unused = ^{if_addr[31:AW+2], if_addr[1:0], d_addr[31:AW+2]};

  // Round-robin: on conflict the port not granted last wins (reset = fetch)
  assign w_gnt_d = d_req & (~if_req | ~r_last_d);

`ifdef MISALIGN_TRAP_EN
  logic r_err;
  assign w_mis  = w_gnt_d &
                  (((d_size == c_SZ_HALF) & d_addr[0]) |
                   ((d_size == c_SZ_WORD) & (d_addr[1:0] != 2'b00)));
  assign w_trap = r_err;
`else
  assign w_mis  = 1'b0;
  assign w_trap = 1'b0;
`endif

  // Fetches always strobe; data strobes unless no-op or trapped
  assign w_en    = ~w_gnt_d | ((d_size != 2'd3) & ~w_mis);
  assign w_store = w_gnt_d & d_we & w_en;

  // Byte-lane mask and lane-replicated write data for the data request
  always_comb begin
    w_mask  = 4'b0000;
    w_wdata = 32'h0;
    case (d_size)
      c_SZ_BYTE: begin
        w_mask  = 4'b0001 << d_addr[1:0];
        w_wdata = {4{d_wdata[7:0]}};
      end
      c_SZ_HALF: begin
        w_mask  = d_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{d_wdata[15:0]}};
      end
      c_SZ_WORD: begin
        w_mask  = 4'b1111;
        w_wdata = d_wdata;
      end
      default: begin
        w_mask  = 4'b0000;
        w_wdata = 32'h0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; a grant happens only in IDLE with a pending request
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (if_req | d_req) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latch the granted access; the grant history drives round-robin
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
      r_gnt_d  <= 1'b0;
      r_we     <= 1'b0;
      r_sign   <= 1'b0;
      r_size   <= 2'd0;
      r_off    <= 2'd0;
    end else if (w_grant) begin
      r_last_d <= w_gnt_d;
      r_gnt_d  <= w_gnt_d;
      r_we     <= w_gnt_d & d_we;
      r_sign   <= w_gnt_d & d_sign;
      r_size   <= w_gnt_d ? d_size : c_SZ_WORD;
      r_off    <= w_gnt_d ? d_addr[1:0] : 2'b00;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Remember whether the granted access trapped
  always_ff @(posedge clk) begin
    if (rst)          r_err <= 1'b0;
    else if (w_grant) r_err <= w_mis;
  end
`endif

  // BRAM strobe registers: loaded on grant so they are live only in ISSUE
  always_ff @(posedge clk) begin
    if (rst || !w_grant) begin
      mem_en    <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
    end else begin
      mem_en    <= w_en;
      mem_we    <= w_store ? w_mask : 4'b0000;
      mem_addr  <= w_en ? (w_gnt_d ? d_addr[AW+1:2] : if_addr[AW+1:2]) : '0;
      mem_wdata <= w_store ? w_wdata : 32'h0;
    end
  end

  // Load data extraction and sign/zero extension from the latched offset
  always_comb begin
    w_lane8  = mem_rdata[{r_off, 3'b000} +: 8];
    w_lane16 = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ext    = 32'h0;
    case (r_size)
      c_SZ_BYTE: w_ext = {{24{r_sign & w_lane8[7]}}, w_lane8};
      c_SZ_HALF: w_ext = {{16{r_sign & w_lane16[15]}}, w_lane16};
      c_SZ_WORD: w_ext = mem_rdata;
      default:   w_ext = 32'h0;
    endcase
  end

  assign w_done   = (r_state == S_DONE);
  assign if_ack   = w_done & ~r_gnt_d;
  assign d_ack    = w_done &  r_gnt_d;
  assign if_rdata = if_ack ? mem_rdata : 32'h0;
  assign d_rdata  = (d_ack & ~r_we & ~w_trap) ? w_ext : 32'h0;
  assign d_err    = d_ack & w_trap;

endmodule
`default_nettype wire
